// File: rtl/fft_transpose_buf.sv
// Ping-pong transpose buffer between two mixed-radix FFT stages.
// A rows x cols frame arrives row-major and leaves column-major, or row-major
// when the frame was written with transpose disabled. Two banks let one
// frame fill while the other drains. The read path is BRAM read register ->
// output register, with a one-entry skid so that m_* stay registered.
module fft_transpose_buf #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4096,
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic             cfg_transpose,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic             m_last,
    output logic             cfg_err,
    output logic [1:0]       bank_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 2 * WIDTH;
    localparam int PW = 2 * DIM_W;
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
    localparam logic [AW-1:0]    AW_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_st_t;

    // Per-bank state and latched frame geometry
    bank_st_t         state_q [2];
    bank_st_t         state_d [2];
    logic [DIM_W-1:0] rows_q  [2];
    logic [DIM_W-1:0] rows_d  [2];
    logic [DIM_W-1:0] cols_q  [2];
    logic [DIM_W-1:0] cols_d  [2];
    logic [1:0]       tr_q, tr_d;

    // Configuration legality
    logic [PW-1:0] cfg_prod;
    logic          cfg_ok_q, cfg_ok_d;

    // Write side
    logic             wr_sel_q, wr_sel_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DIM_W-1:0] wr_row_q, wr_row_d;
    logic [DIM_W-1:0] wr_col_q, wr_col_d;
    logic             wr_fire, wr_first, wr_last;
    logic [DIM_W-1:0] wr_rows, wr_cols;

    // Read issue side (address generation into the bank being read)
    logic             iss_sel_q, iss_sel_d;
    logic             iss_busy_q, iss_busy_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [DIM_W-1:0] rd_row_q, rd_row_d;
    logic [DIM_W-1:0] rd_col_q, rd_col_d;
    logic             iss_start, rd_go, rd_is_last, rd_tr, credit;
    logic [DIM_W-1:0] rd_rows, rd_cols;
    logic [1:0]       occ, occ_after;

    // Release side: bank whose m_last is still to be accepted downstream
    logic rd_sel_q, rd_sel_d;
    logic pop, rel;

    // Read pipeline: BRAM read register stage, output register, skid
    logic          p1_valid_q, p1_valid_d;
    logic          p1_last_q, p1_last_d;
    logic          p1_sel_q, p1_sel_d;
    logic [DW-1:0] bank_rdata [2];
    logic [DW-1:0] in_data;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          sk_valid_q, sk_valid_d;
    logic          sk_last_q, sk_last_d;
    logic [DW-1:0] sk_data_q, sk_data_d;

    // Storage banks: one write port, one registered read port each
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rdata_q;

        // Sample write into the bank currently being filled
        always_ff @(posedge clk) begin
            if (wr_fire && (wr_sel_q == 1'(gi))) begin
                mem[wr_addr_q] <= {s_re, s_im};
            end
        end

        // Synchronous read; holds its value when no read is issued
        always_ff @(posedge clk) begin
            if (rd_go && (iss_sel_q == 1'(gi))) begin
                rdata_q <= mem[rd_addr_q];
            end
        end

        assign bank_rdata[gi] = rdata_q;
    end

    // Legality of the live configuration (the only multiplier in the block)
    always_comb begin
        cfg_prod = {{DIM_W{1'b0}}, cfg_rows} * {{DIM_W{1'b0}}, cfg_cols};
        cfg_ok_d = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_prod <= DEPTH_P);
    end

    // Write side: accept, count row/col, close the frame on its last beat
    always_comb begin
        wr_first  = (state_q[wr_sel_q] == ST_EMPTY);
        s_ready   = cfg_ok_q && (wr_first || (state_q[wr_sel_q] == ST_FILLING));
        wr_fire   = s_valid && s_ready;
        // The first beat sees the bank's geometry before it is latched
        wr_rows   = wr_first ? cfg_rows : rows_q[wr_sel_q];
        wr_cols   = wr_first ? cfg_cols : cols_q[wr_sel_q];
        wr_last   = (wr_row_q == wr_rows - DIM_ONE) && (wr_col_q == wr_cols - DIM_ONE);
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_sel_d  = ~wr_sel_q;
                wr_addr_d = '0;
                wr_row_d  = '0;
                wr_col_d  = '0;
            end else begin
                wr_addr_d = wr_addr_q + AW_ONE;
                if (wr_col_q == wr_cols - DIM_ONE) begin
                    wr_col_d = '0;
                    wr_row_d = wr_row_q + DIM_ONE;
                end else begin
                    wr_col_d = wr_col_q + DIM_ONE;
                end
            end
        end
    end

    // Read issue: incremental address walk, throttled by downstream space
    always_comb begin
        pop       = m_valid_q && m_ready;
        rel       = pop && m_last_q;
        occ       = {1'b0, m_valid_q} + {1'b0, sk_valid_q} + {1'b0, p1_valid_q};
        occ_after = occ - {1'b0, pop};
        // The word issued now lands next cycle; output + skid hold two words
        credit    = (occ_after <= 2'd1);
        iss_start = !iss_busy_q && (state_q[iss_sel_q] == ST_FULL);
        rd_go     = (iss_busy_q || iss_start) && credit;
        rd_rows   = rows_q[iss_sel_q];
        rd_cols   = cols_q[iss_sel_q];
        rd_tr     = tr_q[iss_sel_q];
        rd_is_last = (rd_row_q == rd_rows - DIM_ONE) && (rd_col_q == rd_cols - DIM_ONE);
        iss_sel_d  = iss_sel_q;
        iss_busy_d = iss_busy_q;
        rd_addr_d  = rd_addr_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        rd_sel_d   = rel ? ~rd_sel_q : rd_sel_q;
        if (iss_start) begin
            iss_busy_d = 1'b1;
        end
        if (rd_go) begin
            if (rd_is_last) begin
                // Move straight on to the other bank so frames run gap-free
                iss_busy_d = 1'b0;
                iss_sel_d  = ~iss_sel_q;
                rd_addr_d  = '0;
                rd_row_d   = '0;
                rd_col_d   = '0;
            end else if (rd_tr) begin
                if (rd_row_q == rd_rows - DIM_ONE) begin
                    rd_row_d  = '0;
                    rd_col_d  = rd_col_q + DIM_ONE;
                    rd_addr_d = AW'(rd_col_q) + AW_ONE;
                end else begin
                    rd_row_d  = rd_row_q + DIM_ONE;
                    rd_addr_d = rd_addr_q + AW'(rd_cols);
                end
            end else begin
                rd_addr_d = rd_addr_q + AW_ONE;
                if (rd_col_q == rd_cols - DIM_ONE) begin
                    rd_col_d = '0;
                    rd_row_d = rd_row_q + DIM_ONE;
                end else begin
                    rd_col_d = rd_col_q + DIM_ONE;
                end
            end
        end
    end

    // Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
    always_comb begin
        tr_d      = tr_q;
        bank_full = 2'b00;
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            rows_d[b]  = rows_q[b];
            cols_d[b]  = cols_q[b];
            if (wr_fire && (wr_sel_q == 1'(b))) begin
                if (wr_first) begin
                    rows_d[b]  = cfg_rows;
                    cols_d[b]  = cfg_cols;
                    tr_d[b]    = cfg_transpose;
                    state_d[b] = ST_FILLING;
                end
                if (wr_last) begin
                    state_d[b] = ST_FULL;
                end
            end
            if (iss_start && (iss_sel_q == 1'(b))) begin
                state_d[b] = ST_DRAINING;
            end
            if (rel && (rd_sel_q == 1'(b))) begin
                state_d[b] = ST_EMPTY;
            end
            bank_full[b] = (state_q[b] == ST_FULL) || (state_q[b] == ST_DRAINING);
        end
    end

    // Output register plus skid; data order is output, skid, then read stage
    always_comb begin
        in_data    = bank_rdata[p1_sel_q];
        p1_valid_d = rd_go;
        p1_last_d  = rd_go && rd_is_last;
        p1_sel_d   = rd_go ? iss_sel_q : p1_sel_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        sk_valid_d = sk_valid_q;
        sk_last_d  = sk_last_q;
        sk_data_d  = sk_data_q;
        if (!m_valid_q || pop) begin
            if (sk_valid_q) begin
                m_valid_d  = 1'b1;
                m_last_d   = sk_last_q;
                m_data_d   = sk_data_q;
                sk_valid_d = p1_valid_q;
                if (p1_valid_q) begin
                    sk_last_d = p1_last_q;
                    sk_data_d = in_data;
                end
            end else begin
                m_valid_d = p1_valid_q;
                if (p1_valid_q) begin
                    m_last_d = p1_last_q;
                    m_data_d = in_data;
                end
            end
        end else if (p1_valid_q) begin
            sk_valid_d = 1'b1;
            sk_last_d  = p1_last_q;
            sk_data_d  = in_data;
        end
    end

    // State register for everything except the storage arrays
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= ST_EMPTY;
                rows_q[b]  <= '0;
                cols_q[b]  <= '0;
            end
            tr_q       <= '0;
            cfg_ok_q   <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            iss_sel_q  <= 1'b0;
            iss_busy_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            rd_sel_q   <= 1'b0;
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_sel_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            sk_valid_q <= 1'b0;
            sk_last_q  <= 1'b0;
            sk_data_q  <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                rows_q[b]  <= rows_d[b];
                cols_q[b]  <= cols_d[b];
            end
            tr_q       <= tr_d;
            cfg_ok_q   <= cfg_ok_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            iss_sel_q  <= iss_sel_d;
            iss_busy_q <= iss_busy_d;
            rd_addr_q  <= rd_addr_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            rd_sel_q   <= rd_sel_d;
            p1_valid_q <= p1_valid_d;
            p1_last_q  <= p1_last_d;
            p1_sel_q   <= p1_sel_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
            sk_valid_q <= sk_valid_d;
            sk_last_q  <= sk_last_d;
            sk_data_q  <= sk_data_d;
        end
    end

    assign cfg_err = !cfg_ok_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_re    = m_data_q[DW-1:WIDTH];
    assign m_im    = m_data_q[WIDTH-1:0];

endmodule
